// File: rtl/stream_demux_pkg.sv
// Shared types and limits for the registered stream demultiplexer.
package stream_demux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam int MAX_CH = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register for a single demux channel.
module demux_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              last,
   output logic              free
);

   // A full slot whose consumer is taking the beat can be refilled in the same cycle.
   assign free = !valid || drain;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         last  <= in_last;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-NUM_CH stream demultiplexer with optional per-packet channel locking.
module stream_demux_n
   import stream_demux_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_CH   = 4,
   parameter  int PKT_MODE = 1,
   localparam int SEL_W    = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [DATA_W-1:0]        s_data,
   input  logic [SEL_W-1:0]         s_sel,
   input  logic                     s_last,
   output logic [NUM_CH-1:0]        m_valid,
   input  logic [NUM_CH-1:0]        m_ready,
   output logic [NUM_CH*DATA_W-1:0] m_data,
   output logic [NUM_CH-1:0]        m_last,
   output logic                     err_sel
);

   localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("stream_demux_n: NUM_CH out of range");
   end

   state_t            state;
   logic [SEL_W-1:0]  locked_ch;
   logic [SEL_W-1:0]  tch;
   logic              in_range;
   logic              drop_beat;
   logic              tgt_free;
   logic              accept;
   logic              load_last;
   logic [NUM_CH-1:0] slot_free;

   assign tch       = (PKT_MODE != 0 && state == BUSY) ? locked_ch : s_sel;
   assign in_range  = {1'b0, tch} < CH_LIMIT;
   assign drop_beat = !in_range || state == DROP;
   assign load_last = (PKT_MODE != 0) ? s_last : 1'b0;

   always_comb begin
      tgt_free = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (tch == SEL_W'(k)) tgt_free = slot_free[k];
      end
   end

   // Discarded beats are always swallowed so a bad select can never wedge the producer.
   assign s_ready = drop_beat || tgt_free;
   assign accept  = s_valid && s_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(
         .DATA_W(DATA_W)
      ) u_slot (
         .clk    (clk),
         .rst    (rst),
         .load   (accept && !drop_beat && tch == SEL_W'(k)),
         .drain  (m_ready[k]),
         .in_data(s_data),
         .in_last(load_last),
         .valid  (m_valid[k]),
         .data   (m_data[k*DATA_W +: DATA_W]),
         .last   (m_last[k]),
         .free   (slot_free[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         locked_ch <= '0;
         err_sel   <= 1'b0;
      end else if (accept) begin
         if (state == IDLE && !in_range) err_sel <= 1'b1;
         if (PKT_MODE != 0) begin
            case (state)
               IDLE: begin
                  if (!s_last) begin
                     state     <= in_range ? BUSY : DROP;
                     locked_ch <= s_sel;
                  end
               end
               BUSY, DROP: begin
                  if (s_last) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: directed tables, packet/reset corner cases and a random scoreboard run.
module tb_stream_demux_n;

   typedef struct {
      logic [1:0] sel;
      logic [7:0] data;
      logic       last;
      int         exp_ch;
      logic [7:0] exp_d;
      logic       exp_l;
   } vec_t;

   typedef struct {
      int         ch;
      logic [7:0] data;
      logic       last;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_data;
   logic [1:0]  s_sel;
   logic        s_last;
   logic [3:0]  m_ready;
   logic        v0, v1, v2;
   logic        r0, r1, r2;
   logic [3:0]  mv0, ml0, mv1, ml1;
   logic [31:0] md0, md1;
   logic [2:0]  mv2, ml2;
   logic [23:0] md2;
   logic        e0, e1, e2;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[8];
   sb_t  sbq[$];
   int   accepted = 0;
   int   mst = 0;
   int   mlock = 0;
   logic merr = 1'b0;
   logic holding = 1'b0;

   logic        pstall = 1'b0;
   logic [10:0] pbeat = '0;

   always #5 clk = ~clk;

   stream_demux_n #(.DATA_W(8), .NUM_CH(4), .PKT_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .s_valid(v0), .s_ready(r0), .s_data(s_data), .s_sel(s_sel),
      .s_last(s_last), .m_valid(mv0), .m_ready(m_ready), .m_data(md0), .m_last(ml0), .err_sel(e0)
   );

   stream_demux_n #(.DATA_W(8), .NUM_CH(4), .PKT_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .s_valid(v1), .s_ready(r1), .s_data(s_data), .s_sel(s_sel),
      .s_last(s_last), .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .m_last(ml1), .err_sel(e1)
   );

   stream_demux_n #(.DATA_W(8), .NUM_CH(3), .PKT_MODE(1)) dut2 (
      .clk(clk), .rst(rst), .s_valid(v2), .s_ready(r2), .s_data(s_data), .s_sel(s_sel),
      .s_last(s_last), .m_valid(mv2), .m_ready(m_ready[2:0]), .m_data(md2), .m_last(ml2), .err_sel(e2)
   );

   // A stalled beat on the random-traffic instance must be held unchanged until accepted.
   always @(negedge clk) begin
      if (pstall) begin
         assert (v2 && {s_sel, s_last, s_data} == pbeat)
            else $error("[TB] input beat changed while stalled");
      end
      pstall <= v2 && !r2 && !rst;
      pbeat  <= {s_sel, s_last, s_data};
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int d, input logic valid, input logic [1:0] sel,
                                input logic [7:0] data, input logic last);
      s_sel  = sel;
      s_data = data;
      s_last = last;
      v0     = (d == 0) && valid;
      v1     = (d == 1) && valid;
      v2     = (d == 2) && valid;
   endtask

   function automatic logic [3:0] mvOf(input int d);
      return (d == 0) ? mv0 : mv1;
   endfunction

   function automatic logic [31:0] mdOf(input int d);
      return (d == 0) ? md0 : md1;
   endfunction

   function automatic logic [3:0] mlOf(input int d);
      return (d == 0) ? ml0 : ml1;
   endfunction

   function automatic logic rdyOf(input int d);
      return (d == 0) ? r0 : r1;
   endfunction

   // Beats go in back to back; each one is checked on the cycle after it is driven.
   task automatic runTable(input int d, input int first, input int n);
      vec_t        e;
      logic [31:0] mdat;
      logic [3:0]  mlst;
      for (int i = 0; i <= n; i++) begin
         if (i < n) applyStimulus(d, 1'b1, tbl[first+i].sel, tbl[first+i].data, tbl[first+i].last);
         else       applyStimulus(d, 1'b0, 2'd0, 8'h00, 1'b0);
         #1;
         if (i < n) checkOutput("tbl s_ready", 32'(rdyOf(d)), 32'd1);
         if (i > 0) begin
            e    = tbl[first+i-1];
            mdat = mdOf(d);
            mlst = mlOf(d);
            checkOutput("tbl m_valid", 32'(mvOf(d)), 32'(4'b0001 << e.exp_ch));
            checkOutput("tbl m_data", 32'(mdat[e.exp_ch*8 +: 8]), 32'(e.exp_d));
            checkOutput("tbl m_last", 32'(mlst[e.exp_ch]), 32'(e.exp_l));
         end
         nextCycle();
      end
   endtask

   task automatic randomStep(input bit gen, input bit all_ready);
      int   idx;
      int   tch;
      logic [2:0] rdy;
      for (int k = 0; k < 3; k++) rdy[k] = all_ready || ($urandom_range(0, 9) < 7);
      m_ready = {1'b1, rdy};
      if (!holding) begin
         if (gen && $urandom_range(0, 3) != 0) begin
            applyStimulus(2, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) == 0));
            holding = 1'b1;
         end else begin
            applyStimulus(2, 1'b0, 2'd0, 8'h00, 1'b0);
         end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         if (mv2[k] && m_ready[k]) begin
            idx = -1;
            for (int j = 0; j < sbq.size(); j++) begin
               if (sbq[j].ch == k) begin
                  idx = j;
                  break;
               end
            end
            if (idx < 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL rand unexpected beat ch%0d actual=%0h required=none", k, md2[k*8 +: 8]);
            end else begin
               checkOutput("rand beat", 32'({ml2[k], md2[k*8 +: 8]}), 32'({sbq[idx].last, sbq[idx].data}));
               sbq.delete(idx);
            end
         end
      end
      if (v2 && r2) begin
         accepted++;
         tch = (mst == 1) ? mlock : int'(s_sel);
         if (mst == 2 || tch >= 3) begin
            if (mst == 0) begin
               merr = 1'b1;
               mst  = s_last ? 0 : 2;
            end else if (s_last) begin
               mst = 0;
            end
         end else begin
            sbq.push_back('{ch: tch, data: s_data, last: s_last});
            if (mst == 0 && !s_last) begin
               mst   = 1;
               mlock = tch;
            end else if (mst == 1 && s_last) begin
               mst = 0;
            end
         end
         holding = 1'b0;
      end
      nextCycle();
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 4; i++) begin
         tbl[i] = '{sel: 2'(i), data: 8'(8'h11 * (i + 1)), last: 1'b1,
                    exp_ch: i, exp_d: 8'(8'h11 * (i + 1)), exp_l: 1'b0};
      end
      tbl[4] = '{sel: 2'd1, data: 8'h01, last: 1'b0, exp_ch: 1, exp_d: 8'h01, exp_l: 1'b0};
      tbl[5] = '{sel: 2'd3, data: 8'h02, last: 1'b0, exp_ch: 1, exp_d: 8'h02, exp_l: 1'b0};
      tbl[6] = '{sel: 2'd0, data: 8'h03, last: 1'b1, exp_ch: 1, exp_d: 8'h03, exp_l: 1'b1};
      tbl[7] = '{sel: 2'd3, data: 8'h04, last: 1'b1, exp_ch: 3, exp_d: 8'h04, exp_l: 1'b1};

      rst     = 1'b1;
      m_ready = 4'hF;
      applyStimulus(0, 1'b0, 2'd0, 8'h00, 1'b0);
      repeat (2) nextCycle();
      rst = 1'b0;
      checkOutput("reset m_valid0", 32'(mv0), 32'd0);
      checkOutput("reset m_valid1", 32'(mv1), 32'd0);
      checkOutput("reset m_valid2", 32'(mv2), 32'd0);
      checkOutput("reset m_data0", md0, 32'd0);
      checkOutput("reset err", 32'({e0, e1, e2}), 32'd0);

      $display("[TB] streaming one beat per channel, no packet mode");
      runTable(0, 0, 4);

      $display("[TB] backpressure on channel 2");
      m_ready = 4'b1011;
      applyStimulus(0, 1'b1, 2'd2, 8'hA0, 1'b0);
      #1;
      checkOutput("bp first ready", 32'(r0), 32'd1);
      nextCycle();
      applyStimulus(0, 1'b1, 2'd2, 8'hA1, 1'b0);
      #1;
      checkOutput("bp stall ready", 32'(r0), 32'd0);
      checkOutput("bp held data", 32'(md0[23:16]), 32'hA0);
      nextCycle();
      checkOutput("bp still held", 32'(md0[23:16]), 32'hA0);
      checkOutput("bp still valid", 32'(mv0), 32'b0100);
      m_ready = 4'hF;
      #1;
      checkOutput("bp refill ready", 32'(r0), 32'd1);
      nextCycle();
      applyStimulus(0, 1'b0, 2'd0, 8'h00, 1'b0);
      #1;
      checkOutput("bp refill valid", 32'(mv0), 32'b0100);
      checkOutput("bp refill data", 32'(md0[23:16]), 32'hA1);
      nextCycle();
      checkOutput("bp drained", 32'(mv0), 32'd0);

      $display("[TB] packet mode channel lock");
      runTable(1, 4, 4);

      $display("[TB] out-of-range packet on 3 channels");
      applyStimulus(2, 1'b1, 2'd3, 8'h55, 1'b0);
      #1;
      checkOutput("oor beat0 ready", 32'(r2), 32'd1);
      nextCycle();
      applyStimulus(2, 1'b1, 2'd3, 8'h56, 1'b1);
      #1;
      checkOutput("oor beat1 ready", 32'(r2), 32'd1);
      checkOutput("oor beat0 no valid", 32'(mv2), 32'd0);
      checkOutput("oor err set", 32'(e2), 32'd1);
      nextCycle();
      applyStimulus(2, 1'b1, 2'd1, 8'h77, 1'b1);
      #1;
      checkOutput("oor beat1 no valid", 32'(mv2), 32'd0);
      nextCycle();
      applyStimulus(2, 1'b0, 2'd0, 8'h00, 1'b0);
      #1;
      checkOutput("oor recover valid", 32'(mv2), 32'b010);
      checkOutput("oor recover data", 32'(md2[15:8]), 32'h77);
      checkOutput("oor err sticky", 32'(e2), 32'd1);
      nextCycle();

      $display("[TB] reset during a locked packet");
      m_ready = 4'b1110;
      applyStimulus(1, 1'b1, 2'd0, 8'h90, 1'b0);
      nextCycle();
      applyStimulus(1, 1'b0, 2'd0, 8'h00, 1'b0);
      #1;
      checkOutput("mid-pkt held", 32'(mv1), 32'b0001);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      checkOutput("rst m_valid", 32'(mv1), 32'd0);
      checkOutput("rst m_data", md1, 32'd0);
      checkOutput("rst err", 32'(e2), 32'd0);
      m_ready = 4'hF;
      applyStimulus(1, 1'b1, 2'd2, 8'h91, 1'b1);
      nextCycle();
      applyStimulus(1, 1'b0, 2'd0, 8'h00, 1'b0);
      #1;
      checkOutput("post-rst route", 32'(mv1), 32'b0100);
      checkOutput("post-rst data", 32'(md1[23:16]), 32'h91);
      nextCycle();

      $display("[TB] random traffic on 3 channels");
      cyc = 0;
      while (accepted < 2000 && cyc < 20000) begin
         randomStep(1'b1, 1'b0);
         cyc++;
      end
      checkOutput("rand accepted", 32'(accepted), 32'd2000);
      repeat (8) randomStep(1'b0, 1'b1);
      checkOutput("rand leftover", 32'(sbq.size()), 32'd0);
      checkOutput("rand err", 32'(e2), 32'(merr));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
